// File: rtl/arp_ctrl_if.sv
// ---------------------------------------------------------------------------
// arp_ctrl_if : link between arp_ctrl and the ARP rx/tx block.
//
// Signals
//   arp_rx_done  rx block -> ctrl  one-cycle pulse, packet received/decoded
//   arp_rx_type  rx block -> ctrl  0 = request, 1 = reply (valid with done)
//   src_mac      rx block -> ctrl  sender MAC (valid with arp_rx_done)
//   src_ip       rx block -> ctrl  sender IP  (valid with arp_rx_done)
//   tx_done      tx block -> ctrl  one-cycle pulse, frame fully sent
//   arp_tx_en    ctrl -> tx block  one-cycle pulse, start a transmission
//   arp_tx_type  ctrl -> tx block  0 = request, 1 = reply
//   des_mac      ctrl -> tx block  destination MAC
//   des_ip       ctrl -> tx block  destination IP
//
// Handshake: there is no ready/backpressure.  arp_rx_done qualifies
// arp_rx_type/src_mac/src_ip for exactly that one cycle.  arp_tx_en is a
// single-cycle start strobe; arp_tx_type/des_mac/des_ip are valid on that
// cycle and stay stable until the tx block answers with a one-cycle tx_done.
// arp_tx_en is never raised again before that tx_done.
//
// Modports: master = arp_ctrl, slave = ARP rx/tx block.
// ---------------------------------------------------------------------------
interface arp_ctrl_if;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic        tx_done;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;

    modport master (
        input  arp_rx_done, arp_rx_type, src_mac, src_ip, tx_done,
        output arp_tx_en, arp_tx_type, des_mac, des_ip
    );

    modport slave (
        output arp_rx_done, arp_rx_type, src_mac, src_ip, tx_done,
        input  arp_tx_en, arp_tx_type, des_mac, des_ip
    );
endinterface

// File: rtl/arp_ctrl.sv
// ---------------------------------------------------------------------------
// arp_ctrl : user-side controller around the ARP rx/tx block.
//   - answers every received ARP request with a reply
//   - resolves a user IP on demand, retrying on timeout
//   - keeps a single-entry MAC/IP cache for the UDP transmit path
//
// Ports
//   clk, rst      GMII clock, asynchronous active-high reset
//   arp           arp_ctrl_if.master link to the ARP rx/tx block
//   req_start     one-cycle pulse: resolve req_ip
//   req_ip        IP to resolve, sampled with req_start
//   cache_valid   cache_mac/cache_ip hold a resolved pair
//   cache_mac     resolved MAC
//   cache_ip      resolved IP
//   resolve_fail  one-cycle pulse: retries exhausted without a reply
//   busy          FSM not in IDLE
//   state_dbg     current FSM state encoding
// ---------------------------------------------------------------------------
module arp_ctrl #(
    parameter int TIMEOUT_CYC = 125_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    arp_ctrl_if.master  arp,
    input  logic        req_start,
    input  logic [31:0] req_ip,
    output logic        cache_valid,
    output logic [47:0] cache_mac,
    output logic [31:0] cache_ip,
    output logic        resolve_fail,
    output logic        busy,
    output logic [2:0]  state_dbg
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] SEND_REP   = 3'd1;
    localparam logic [2:0] SEND_REQ   = 3'd2;
    localparam logic [2:0] WAIT_DONE  = 3'd3;
    localparam logic [2:0] WAIT_REPLY = 3'd4;

    logic [2:0]    state, state_nx;
    logic          rep_pend;
    logic [47:0]   rep_mac;
    logic [31:0]   rep_ip;
    logic          req_pend;
    logic [31:0]   target;      // last requested IP (req_start)
    logic [31:0]   cur_ip;      // IP of the resolution in progress
    logic          outstanding;
    logic          tmo;
    logic [3:0]    retry_cnt;
    logic [TW-1:0] timer;
    logic          tx_en, tx_type;
    logic [47:0]   tx_mac;
    logic [31:0]   tx_ip;

    logic go_rep, go_req, restart, fail, drop_req;
    logic rx_req, rx_match, expire, tmo_now;

    assign rx_req   = arp.arp_rx_done && !arp.arp_rx_type;
    assign rx_match = arp.arp_rx_done && arp.arp_rx_type && outstanding &&
                      (arp.src_ip == target);
    // Expiry is seen the cycle the timer hits its last count so that
    // retransmissions land exactly TIMEOUT_CYC cycles apart.
    assign expire   = outstanding && (timer == TW'(1));
    assign tmo_now  = tmo || expire;

    always_comb begin
        state_nx = state;
        go_rep   = 1'b0;
        go_req   = 1'b0;
        restart  = 1'b0;
        fail     = 1'b0;
        drop_req = 1'b0;
        case (state)
            IDLE: begin
                if (rep_pend) begin
                    state_nx = SEND_REP;
                    go_rep   = 1'b1;
                end else if (req_pend) begin
                    state_nx = SEND_REQ;
                    go_req   = 1'b1;
                    restart  = 1'b1;
                end
            end
            SEND_REP, SEND_REQ: state_nx = WAIT_DONE;
            WAIT_DONE: begin
                if (arp.tx_done)
                    state_nx = (outstanding && !rx_match) ? WAIT_REPLY : IDLE;
            end
            WAIT_REPLY: begin
                // A matching reply beats a simultaneous timer expiry.
                if (rx_match) begin
                    state_nx = IDLE;
                end else if (rep_pend) begin
                    state_nx = SEND_REP;
                    go_rep   = 1'b1;
                end else if (req_pend && (target != cur_ip)) begin
                    state_nx = SEND_REQ;
                    go_req   = 1'b1;
                    restart  = 1'b1;
                end else if (req_pend) begin
                    drop_req = 1'b1;    // same IP already being resolved
                end else if (tmo_now) begin
                    if (retry_cnt < 4'(MAX_RETRY)) begin
                        state_nx = SEND_REQ;
                        go_req   = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        fail     = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Later statements win: new pending events (set) override the clears
    // issued by the FSM in the same cycle, so no request is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rep_pend     <= 1'b0;
            rep_mac      <= '0;
            rep_ip       <= '0;
            req_pend     <= 1'b0;
            target       <= '0;
            cur_ip       <= '0;
            outstanding  <= 1'b0;
            tmo          <= 1'b0;
            retry_cnt    <= '0;
            timer        <= '0;
            tx_en        <= 1'b0;
            tx_type      <= 1'b0;
            tx_mac       <= '0;
            tx_ip        <= '0;
            cache_valid  <= 1'b0;
            cache_mac    <= '0;
            cache_ip     <= '0;
            resolve_fail <= 1'b0;
        end else begin
            state        <= state_nx;
            tx_en        <= 1'b0;
            resolve_fail <= 1'b0;

            // Timer keeps running while a reply is being sent in between.
            if (outstanding && (timer != '0)) begin
                timer <= timer - TW'(1);
                if (expire)
                    tmo <= 1'b1;
            end

            if (go_rep) begin
                tx_en    <= 1'b1;
                tx_type  <= 1'b1;
                tx_mac   <= rep_mac;
                tx_ip    <= rep_ip;
                rep_pend <= 1'b0;
            end

            if (go_req) begin
                tx_en       <= 1'b1;
                tx_type     <= 1'b0;
                tx_mac      <= '1;
                tx_ip       <= target;
                timer       <= TW'(TIMEOUT_CYC);
                tmo         <= 1'b0;
                outstanding <= 1'b1;
                if (restart) begin
                    retry_cnt <= 4'd1;
                    cur_ip    <= target;
                    req_pend  <= 1'b0;
                end else begin
                    retry_cnt <= retry_cnt + 4'd1;
                end
            end

            if (drop_req)
                req_pend <= 1'b0;

            if (fail) begin
                resolve_fail <= 1'b1;
                outstanding  <= 1'b0;
                tmo          <= 1'b0;
            end

            if (req_start) begin
                req_pend <= 1'b1;
                target   <= req_ip;
                if (req_ip != cache_ip)
                    cache_valid <= 1'b0;
            end

            if (rx_match) begin
                cache_valid <= 1'b1;
                cache_mac   <= arp.src_mac;
                cache_ip    <= arp.src_ip;
                outstanding <= 1'b0;
                tmo         <= 1'b0;
            end

            if (rx_req) begin
                rep_pend <= 1'b1;
                rep_mac  <= arp.src_mac;
                rep_ip   <= arp.src_ip;
            end
        end
    end

    assign arp.arp_tx_en   = tx_en;
    assign arp.arp_tx_type = tx_type;
    assign arp.des_mac     = tx_mac;
    assign arp.des_ip      = tx_ip;
    assign busy            = (state != IDLE);
    assign state_dbg       = state;
endmodule

// File: tb/tb_arp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arp_ctrl : directed bench for arp_ctrl.
//   Stimulus pushes each expected ARP frame {type, des_mac, des_ip} into
//   exp_q; a negedge monitor (which also models the ARP tx block, answering
//   every start with tx_done after TX_LEN cycles) pops and compares.
// ---------------------------------------------------------------------------
module tb_arp_ctrl;
    localparam int T      = 100;
    localparam int MAXR   = 3;
    localparam int TX_LEN = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_start;
    logic [31:0] req_ip;
    logic        cache_valid;
    logic [47:0] cache_mac;
    logic [31:0] cache_ip;
    logic        resolve_fail;
    logic        busy;
    logic [2:0]  state_dbg;

    arp_ctrl_if arp();

    arp_ctrl #(.TIMEOUT_CYC(T), .MAX_RETRY(MAXR)) dut (
        .clk          (clk),
        .rst          (rst),
        .arp          (arp),
        .req_start    (req_start),
        .req_ip       (req_ip),
        .cache_valid  (cache_valid),
        .cache_mac    (cache_mac),
        .cache_ip     (cache_ip),
        .resolve_fail (resolve_fail),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [80:0] exp_q[$];
    int          tx_cyc[$];
    int          tx_count   = 0;
    int          fail_count = 0;
    int          fail_cyc   = 0;
    bit          in_flight  = 0;
    bit          held_ok    = 1;
    logic [80:0] held;
    int          tx_left    = 0;
    int          rx_cyc     = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor + ARP tx block model ----------------
    always @(negedge clk) begin
        logic [80:0] act;
        logic [80:0] exp_v;
        act = {arp.arp_tx_type, arp.des_mac, arp.des_ip};
        if (rst) begin
            in_flight   = 0;
            arp.tx_done = 1'b0;
        end else if (in_flight) begin
            if (arp.arp_tx_en) begin
                checks++;
                errors++;
                $display("FAIL tx_en_before_done: got arp_tx_en=1, expected 0 at cycle %0d", cyc);
            end
            if (act !== held)
                held_ok = 0;
            if (arp.tx_done) begin
                arp.tx_done = 1'b0;
                in_flight   = 0;
                chk("tx_held_stable", held_ok, 1'b1);
            end else if (tx_left == 0) begin
                arp.tx_done = 1'b1;
            end else begin
                tx_left--;
            end
        end else if (arp.arp_tx_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got frame %h, expected none", act);
            end else begin
                exp_v = exp_q.pop_front();
                chk("tx_frame", act, exp_v);
            end
            tx_count++;
            tx_cyc.push_back(cyc);
            in_flight = 1;
            held      = act;
            held_ok   = 1;
            tx_left   = TX_LEN;
        end
        if (!rst && resolve_fail) begin
            fail_count++;
            fail_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_rx(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        @(negedge clk);
        rx_cyc          = cyc;
        arp.arp_rx_done = 1'b1;
        arp.arp_rx_type = typ;
        arp.src_mac     = mac;
        arp.src_ip      = ip;
        @(negedge clk);
        arp.arp_rx_done = 1'b0;
    endtask

    task automatic drive_req(input logic [31:0] ip);
        @(negedge clk);
        req_start = 1'b1;
        req_ip    = ip;
        @(negedge clk);
        req_start = 1'b0;
    endtask

    task automatic send_both(input logic [47:0] mac, input logic [31:0] ip, input logic [31:0] rip);
        @(negedge clk);
        arp.arp_rx_done = 1'b1;
        arp.arp_rx_type = 1'b0;
        arp.src_mac     = mac;
        arp.src_ip      = ip;
        req_start       = 1'b1;
        req_ip          = rip;
        @(negedge clk);
        arp.arp_rx_done = 1'b0;
        req_start       = 1'b0;
    endtask

    // wait until n frames have started and the last one has completed
    task automatic wait_tx(input int n, input int budget, input string name);
        int k = 0;
        while (!(tx_count >= n && !in_flight) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, (k < budget), 1'b1);
    endtask

    task automatic wait_started(input int n, input int budget, input string name);
        int k = 0;
        while (tx_count < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, (k < budget), 1'b1);
    endtask

    task automatic wait_fail(input int fc0, input int budget);
        int k = 0;
        while (fail_count <= fc0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("fail_wait", (k < budget), 1'b1);
    endtask

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    // ---------------- main stimulus ----------------
    initial begin
        int n0, s, fc0, lat;
        rst             = 1'b1;
        req_start       = 1'b0;
        req_ip          = '0;
        arp.arp_rx_done = 1'b0;
        arp.arp_rx_type = 1'b0;
        arp.src_mac     = '0;
        arp.src_ip      = '0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_tx_en", arp.arp_tx_en, 1'b0);
        chk("rst_tx_frame", {arp.arp_tx_type, arp.des_mac, arp.des_ip}, 81'd0);
        chk("rst_cache", {cache_valid, cache_mac, cache_ip}, 81'd0);
        chk("rst_fail_busy", {resolve_fail, busy}, 2'b00);
        chk("rst_state", state_dbg, 3'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: incoming request answered with a reply
        exp_q.push_back({1'b1, 48'h84A9_38BF_C9A0, 32'hA9FE_3378});
        n0 = tx_count;
        send_rx(1'b0, 48'h84A9_38BF_C9A0, 32'hA9FE_3378);
        wait_started(n0 + 1, 10, "t1_start");
        lat = tx_cyc[tx_cyc.size() - 1] - rx_cyc;
        chk("t1_latency", (lat >= 1 && lat <= 2), 1'b1);
        @(negedge clk);
        chk("t1_busy_in_flight", busy, 1'b1);
        wait_tx(n0 + 1, 40, "t1_done");
        @(negedge clk);
        chk("t1_busy_after", busy, 1'b0);

        // 2: resolve C0A80102, matching reply fills the cache
        exp_q.push_back({1'b0, BCAST, 32'hC0A8_0102});
        n0 = tx_count;
        drive_req(32'hC0A8_0102);
        wait_tx(n0 + 1, 40, "t2_done");
        @(negedge clk);
        chk("t2_busy_waiting", busy, 1'b1);
        send_rx(1'b1, 48'h0011_2233_4455, 32'hC0A8_0102);
        @(negedge clk);
        chk("t2_cache", {cache_valid, cache_mac, cache_ip}, {1'b1, 48'h0011_2233_4455, 32'hC0A8_0102});
        chk("t2_busy", busy, 1'b0);

        // 3: no reply -> three requests 100 cycles apart, then resolve_fail
        for (int i = 0; i < MAXR; i++)
            exp_q.push_back({1'b0, BCAST, 32'hC0A8_0103});
        n0  = tx_count;
        s   = tx_cyc.size();
        fc0 = fail_count;
        drive_req(32'hC0A8_0103);
        @(negedge clk);
        chk("t3_cache_cleared", cache_valid, 1'b0);
        wait_fail(fc0, 400);
        chk("t3_frames", tx_count - n0, 32'd3);
        if (tx_cyc.size() >= s + 3) begin
            chk("t3_gap1", tx_cyc[s + 1] - tx_cyc[s], 32'd100);
            chk("t3_gap2", tx_cyc[s + 2] - tx_cyc[s + 1], 32'd100);
            chk("t3_fail_gap", fail_cyc - tx_cyc[s + 2], 32'd100);
        end
        repeat (5) @(negedge clk);
        chk("t3_fail_pulses", fail_count - fc0, 32'd1);
        chk("t3_cache_valid", cache_valid, 1'b0);
        chk("t3_idle", busy, 1'b0);

        // 4: reply sent mid-wait; retry still on schedule; then resolved
        exp_q.push_back({1'b0, BCAST, 32'hC0A8_0104});
        n0 = tx_count;
        s  = tx_cyc.size();
        drive_req(32'hC0A8_0104);
        wait_tx(n0 + 1, 40, "t4_req_done");
        repeat (5) @(negedge clk);
        exp_q.push_back({1'b1, 48'h0200_0000_0001, 32'h0A00_0001});
        send_rx(1'b0, 48'h0200_0000_0001, 32'h0A00_0001);
        wait_tx(n0 + 2, 40, "t4_rep_done");
        exp_q.push_back({1'b0, BCAST, 32'hC0A8_0104});
        wait_tx(n0 + 3, 150, "t4_retry_done");
        if (tx_cyc.size() >= s + 3)
            chk("t4_retry_gap", tx_cyc[s + 2] - tx_cyc[s], 32'd100);
        send_rx(1'b1, 48'h6677_8899_AABB, 32'hC0A8_0104);
        @(negedge clk);
        chk("t4_cache", {cache_valid, cache_mac, cache_ip}, {1'b1, 48'h6677_8899_AABB, 32'hC0A8_0104});
        chk("t4_busy", busy, 1'b0);

        // 5: simultaneous rx request and req_start -> reply first
        exp_q.push_back({1'b1, 48'h0A1B_2C3D_4E5F, 32'h0A00_0002});
        exp_q.push_back({1'b0, BCAST, 32'hC0A8_0105});
        n0 = tx_count;
        s  = tx_cyc.size();
        send_both(48'h0A1B_2C3D_4E5F, 32'h0A00_0002, 32'hC0A8_0105);
        wait_tx(n0 + 2, 80, "t5_done");
        if (tx_cyc.size() >= s + 2)
            chk("t5_after_done", (tx_cyc[s + 1] - tx_cyc[s]) > TX_LEN, 1'b1);
        send_rx(1'b1, 48'hAABB_CCDD_EEFF, 32'hC0A8_0105);
        @(negedge clk);
        chk("t5_cache", {cache_valid, cache_mac, cache_ip}, {1'b1, 48'hAABB_CCDD_EEFF, 32'hC0A8_0105});

        // 6: non-matching reply ignored, timeout retry still happens
        exp_q.push_back({1'b0, BCAST, 32'hC0A8_0102});
        n0 = tx_count;
        s  = tx_cyc.size();
        drive_req(32'hC0A8_0102);
        wait_tx(n0 + 1, 40, "t6_req_done");
        send_rx(1'b1, 48'hDEAD_BEEF_0001, 32'hC0A8_0199);
        @(negedge clk);
        chk("t6_ignored", {cache_valid, busy}, 2'b01);
        exp_q.push_back({1'b0, BCAST, 32'hC0A8_0102});
        wait_tx(n0 + 2, 150, "t6_retry_done");
        if (tx_cyc.size() >= s + 2)
            chk("t6_retry_gap", tx_cyc[s + 1] - tx_cyc[s], 32'd100);
        send_rx(1'b1, 48'h0011_2233_4455, 32'hC0A8_0102);
        @(negedge clk);
        chk("t6_cache", {cache_valid, cache_mac, cache_ip}, {1'b1, 48'h0011_2233_4455, 32'hC0A8_0102});

        repeat (5) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arp_ctrl.md
Name: arp_ctrl

Overview:
- User-side controller that closes the ARP loop around the ARP rx/tx block.
- Answers every received ARP request with an ARP reply.
- Issues ARP requests on user demand, retrying on timeout.
- Holds a single-entry MAC/IP cache that the UDP transmit path uses as its destination.
- Runs in the GMII clock domain, between the ARP block's user interface and the UDP top-level.

Parameters:
TIMEOUT_CYC, 125_000_000, cycles to wait for an ARP reply before retrying (1 s at 125 MHz).
MAX_RETRY, 3, total request transmissions before declaring failure (range 1..15).

Ports:
clk  in  1  GMII tx/rx clock (ARP block runs on the same clock).
rst  in  1  asynchronous reset, active-high.
arp_rx_done  in  1  one-cycle pulse: ARP packet received and decoded.
arp_rx_type  in  1  0 = request, 1 = reply; valid with arp_rx_done.
src_mac  in  48  sender MAC of the received packet; valid with arp_rx_done.
src_ip  in  32  sender IP of the received packet; valid with arp_rx_done.
tx_done  in  1  one-cycle pulse: ARP frame fully transmitted.
arp_tx_en  out  1  one-cycle pulse: start an ARP transmission.
arp_tx_type  out  1  0 = request, 1 = reply; held stable from arp_tx_en until tx_done.
des_mac  out  48  destination MAC for the transmission; held until tx_done.
des_ip  out  32  destination IP for the transmission; held until tx_done.
req_start  in  1  one-cycle pulse: resolve req_ip.
req_ip  in  32  IP address to resolve; sampled with req_start.
cache_valid  out  1  cache_mac/cache_ip hold a resolved pair.
cache_mac  out  48  resolved MAC.
cache_ip  out  32  resolved IP.
resolve_fail  out  1  one-cycle pulse: retries exhausted without a reply.
busy  out  1  high when state is not IDLE.

Behaviour:
- Reset: every output is 0. Internal state = IDLE; pending flags, counters and target register are cleared.
- States:
  - IDLE
  - SEND_REP
  - SEND_REQ
  - WAIT_DONE
  - WAIT_REPLY
- Pending reply:
  - arp_rx_done with type 0, in any state, latches {src_mac, src_ip} into the reply-pending registers and sets rep_pend.
  - The slot is one deep; a newer request overwrites the older one.
- Pending user request:
  - req_start in any state latches req_ip into the target register and sets req_pend.
  - It also clears cache_valid the next cycle if req_ip != cache_ip.
  - A newer req_start overwrites the older one.
- Arbitration in IDLE and WAIT_REPLY: rep_pend has priority over req_pend.
  - IDLE with rep_pend -> SEND_REP.
  - IDLE with req_pend -> SEND_REQ; clears req_pend and resets the retry count to 0.
- SEND_REP (1 cycle): arp_tx_en = 1, arp_tx_type = 1, des_mac/des_ip = pending pair; clear rep_pend; -> WAIT_DONE.
- SEND_REQ (1 cycle): arp_tx_en = 1, arp_tx_type = 0, des_mac = 48'hFF_FF_FF_FF_FF_FF, des_ip = target; retry count +1; load the timer with TIMEOUT_CYC; -> WAIT_DONE.
- WAIT_DONE: on tx_done -> return state.
  - Return state is WAIT_REPLY if a resolution is outstanding, else IDLE.
  - arp_tx_en is never reasserted before tx_done.
- WAIT_REPLY:
  - The timer decrements every cycle, including while a reply is being sent via SEND_REP/WAIT_DONE.
  - Timer expiry sets the sticky flag tmo.
  - In WAIT_REPLY, rep_pend -> SEND_REP; the resolution stays outstanding.
  - tmo and retry count < MAX_RETRY -> SEND_REQ; clear tmo.
  - tmo and retry count == MAX_RETRY -> pulse resolve_fail, clear outstanding, -> IDLE.
  - req_pend with a new target restarts resolution: -> SEND_REQ with retry count reset to 0.
- Reply matching:
  - arp_rx_done with type 1 and src_ip == target while outstanding (any state) loads cache_mac = src_mac, cache_ip = src_ip, cache_valid = 1 the next cycle.
  - It clears outstanding and tmo; WAIT_REPLY -> IDLE.
  - Non-matching or unsolicited replies are ignored.
- Simultaneous match and timer expiry in the same cycle: the match wins; no retry, no resolve_fail.
- Simultaneous arp_rx_done and req_start: both are latched; the reply is sent first.
- rst mid-transfer: returns to IDLE immediately and drops arp_tx_en. The ARP tx block shares rst, so no handshake is left dangling.

Test Plan:
- Request from MAC 84_A9_38_BF_C9_A0, IP 169.254.51.120 while IDLE -> within 2 cycles a single arp_tx_en pulse with type=1, des_mac=84_A9_38_BF_C9_A0, des_ip=A9FE3378; busy until tx_done.
- req_start, req_ip=C0A80102 -> arp_tx_en with type=0, des_mac=FFFF_FFFF_FFFF; matching reply with MAC 00_11_22_33_44_55 -> cache_valid=1, cache_mac=001122334455, busy=0.
- TIMEOUT_CYC=100, MAX_RETRY=3, no reply -> exactly 3 request frames spaced 100 cycles apart, then one resolve_fail pulse; cache_valid stays 0.
- During WAIT_REPLY an ARP request arrives -> reply frame sent; the original request is retried on schedule; a subsequent matching reply is still cached.
- arp_rx_done and req_start in the same cycle -> reply frame first, request frame after its tx_done.
- Reply with src_ip=C0A80199 while resolving C0A80102 -> ignored; timeout retry still occurs.
